// File: rtl/credit_output_arbiter.sv
// Per-output wormhole allocator: round-robin head arbitration, lock until tail, credit flow control.
// Optional idle-lock timeout release is enabled with `define ARB_LOCK_TIMEOUT_EN.
module credit_output_arbiter #(
  parameter int CREDIT_MAX  = 4,
  parameter int CNT_W       = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Req,
  input  logic [4:0]       Tail,
  input  logic             Credit_in,
  output logic [4:0]       Grant,
  output logic [4:0]       Xbar_sel,
  output logic [CNT_W-1:0] Credits,
  output logic             Busy,
  output logic             Credit_err,
  output logic             Lock_abort,
  output logic             dbg_state
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state;
  logic [2:0] owner;
  logic [2:0] last_owner;
  logic [2:0] rr_winner;
  logic       grant_ok;

  // Handshake: a flit moves when Grant[i] is high; Req[i] is the valid, credit availability is the ready.
  function automatic logic [2:0] rr_pick(input logic [2:0] last, input logic [4:0] req);
    logic [2:0] pick;
    logic [3:0] idx;
    pick = last;
    // Walk from lowest to highest priority so the highest-priority requester is written last.
    for (int k = 5; k >= 1; k--) begin
      idx = {1'b0, last} + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (req[idx[2:0]]) pick = idx[2:0];
    end
    return pick;
  endfunction

  assign rr_winner = rr_pick(last_owner, Req);
  assign grant_ok  = !rst && (state == LOCKED) && Req[owner] && (Credits != '0);
  assign Grant     = grant_ok ? (5'b00001 << owner) : 5'b00000;
  assign dbg_state = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      Credits    <= CNT_W'(CREDIT_MAX);
      Credit_err <= 1'b0;
    end else begin
      case ({grant_ok, Credit_in})
        2'b10: Credits <= Credits - 1'b1;
        2'b01: begin
          if (Credits == CNT_W'(CREDIT_MAX)) Credit_err <= 1'b1;
          else                               Credits    <= Credits + 1'b1;
        end
        default: Credits <= Credits;
      endcase
    end
  end

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign Lock_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 3'd0;
      last_owner <= 3'd3;
      Xbar_sel   <= 5'b00000;
      Busy       <= 1'b0;
`ifdef ARB_LOCK_TIMEOUT_EN
      to_cnt     <= '0;
      Lock_abort <= 1'b0;
`endif
    end else begin
`ifdef ARB_LOCK_TIMEOUT_EN
      Lock_abort <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|Req) begin
            state    <= LOCKED;
            owner    <= rr_winner;
            Xbar_sel <= 5'b00001 << rr_winner;
            Busy     <= 1'b1;
          end
        end
        LOCKED: begin
          if (grant_ok && Tail[owner]) begin
            state      <= IDLE;
            last_owner <= owner;
            Xbar_sel   <= 5'b00000;
            Busy       <= 1'b0;
`ifdef ARB_LOCK_TIMEOUT_EN
            to_cnt     <= '0;
          end else if (!Req[owner]) begin
            if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
              state      <= IDLE;
              last_owner <= owner;
              Xbar_sel   <= 5'b00000;
              Busy       <= 1'b0;
              Lock_abort <= 1'b1;
              to_cnt     <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end else begin
            to_cnt <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
